floor_code_decoder_ctrl: RTL
============================

Name: floor_code_decoder_ctrl

Overview:
- Consumer end of the floor-request path: accepts a 3-bit encoded target floor (as produced by the priority-encoded call panel) over a valid/ready handshake.
- Decodes the request to one-hot.
- Steps the car one floor at a time toward the target, then runs a timed door-open phase.
- Drives floor indicator lamps, motor direction and door outputs for the elevator car.

Parameters:
- NUM_FLOORS, 8: number of served floors. Must satisfy 2 <= NUM_FLOORS <= 2**FLOOR_W.
- FLOOR_W, 3: width of the encoded floor code.
- TRAVEL_CYCLES, 4: clock cycles spent moving per floor (>=1).
- DOOR_CYCLES, 6: clock cycles the door stays open (>=1).

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  encoded floor request present
- req_floor  in  FLOOR_W  encoded target floor
- req_ready  out  1  block can accept a request
- cur_floor_oh  out  NUM_FLOORS  one-hot current car position (indicator lamps)
- target_oh  out  NUM_FLOORS  one-hot latched target; 0 when idle
- move_up  out  1  motor up command
- move_down  out  1  motor down command
- door_open  out  1  door open command
- arrived  out  1  one-cycle pulse on arrival at target
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clock edge, taking priority over all else, including mid-move or mid-door):
  - state=IDLE, current floor=0, cur_floor_oh=1.
  - target_oh=0; move_up, move_down, door_open, arrived, busy all 0.
  - Travel and door counters are cleared.
  - req_ready=1 from the first cycle after reset is released.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. All outputs are registered.
- Handshake:
  - req_ready=1 only in IDLE.
  - A request is accepted in cycle T when req_valid && req_ready.
  - req_valid asserted while busy is ignored. Requests are not queued.
- Out-of-range codes (req_floor >= NUM_FLOORS) are accepted and discarded: no state change, target_oh stays 0.
- Same-floor request accepted at T:
  - From T+1: state=DOOR_OPEN, arrived=1 for that cycle only.
  - No movement occurs.
- Different-floor request accepted at T:
  - From T+1: target_oh=onehot(req_floor).
  - State is MOVE_UP if target > current, else MOVE_DOWN; move_up/move_down follows the state.
- Movement:
  - The travel counter counts TRAVEL_CYCLES cycles per floor.
  - On the last cycle the floor increments (up) or decrements (down); cur_floor_oh updates the next cycle.
  - When the updated floor equals the target, the next state is DOOR_OPEN. move_* drops the same cycle the floor reaches the target.
  - Example: 0->3 with TRAVEL_CYCLES=4, accepted at T:
    - move_up high T+1..T+12.
    - Floor visible as 1 at T+5, 2 at T+9, 3 at T+13.
    - arrived and door_open rise at T+13.
- Door phase:
  - door_open is high for exactly DOOR_CYCLES cycles; arrived pulses only in the first of them.
  - Then state=IDLE, target_oh=0, req_ready=1.
- Invariants:
  - move_up, move_down and door_open are mutually exclusive.
  - cur_floor_oh is always exactly one-hot.
  - The floor never leaves 0..NUM_FLOORS-1; no wrap-around.

Optional Feature:
- Macro DOOR_HOLD_EN.
- When defined: adds input port door_hold (1 bit). While in DOOR_OPEN, door_hold=1 reloads the door counter, so the door stays open until DOOR_CYCLES cycles after the last cycle door_hold was high. door_hold has no effect outside DOOR_OPEN.
- When undefined: no door_hold port; the door time is fixed at DOOR_CYCLES.

Decomposition:
- Package elevator_pkg holds:
  - state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN)
  - floor_t typedef (logic [FLOOR_W-1:0])
  - default constants for floor count and widths
- One sub-module: floor_onehot_decoder, a parameterised binary-to-one-hot decoder with an enable input. All-zero output when disabled or out of range.
  - Instantiated twice: for cur_floor_oh, and for target_oh with enable=busy.

Test Plan:
- Reset, then hold rst_n=1 for 3 cycles -> cur_floor_oh=8'h01, target_oh=0, req_ready=1, all commands 0.
- Request floor 3 from floor 0 (TRAVEL=4, DOOR=6) accepted at T:
  - move_up for T+1..T+12, floor 3 visible at T+13.
  - arrived is a single pulse at T+13; door_open for T+13..T+18.
  - req_ready=1 at T+19.
- From floor 7, request floor 2:
  - move_down for 20 cycles; cur_floor_oh steps 80,40,20,10,08,04.
  - door_open then follows.
- Request the current floor 4 -> door_open for 6 cycles starting T+1, arrived pulse at T+1, move_up/move_down never high.
- During MOVE_UP, hold req_valid=1 with req_floor=6 -> req_ready=0 and the request is ignored. Assert rst_n=0 mid-move -> next cycle floor=0, state IDLE, outputs at reset values.
- NUM_FLOORS=6, request code 7 -> accepted, no movement, busy stays 0. With DOOR_HOLD_EN, pulse door_hold in door cycle 4 -> door_open extends to 6 cycles after the pulse.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator floor-request path.
// Contents:
//   state_e   - controller state encoding (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN)
//   floor_t   - encoded floor code at the default code width
//   DEF_*     - default floor count, code width and phase durations
//   cnt_width - width of a counter that must hold values 0..n-1
package elevator_pkg;

    localparam int DEF_NUM_FLOORS    = 8;
    localparam int DEF_FLOOR_W       = 3;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 6;

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/floor_code_decoder_ctrl_if.sv
// Request handshake between the call panel (master) and the car
// controller (slave).
// Signals:
//   req_valid - encoded floor request present (master -> slave)
//   req_floor - encoded target floor          (master -> slave)
//   req_ready - controller can take a request (slave -> master)
interface floor_code_decoder_ctrl_if
    import elevator_pkg::*;
#(
    parameter int FLOOR_W = DEF_FLOOR_W
);
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;

    modport master (output req_valid, output req_floor, input req_ready);
    modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/floor_onehot_decoder.sv
// Binary floor code to one-hot decoder with enable.
// Ports:
//   en     - when low the output is all zero
//   code   - binary floor code
//   onehot - one-hot floor; all zero when disabled or code >= NUM_FLOORS
module floor_onehot_decoder
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_W    = DEF_FLOOR_W
) (
    input  logic                  en,
    input  logic [FLOOR_W-1:0]    code,
    output logic [NUM_FLOORS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (en && (code == FLOOR_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/floor_code_decoder_ctrl.sv
// Elevator car controller: takes an encoded target floor over a
// valid/ready handshake, steps the car one floor per TRAVEL_CYCLES toward
// it, then holds the door open for DOOR_CYCLES.
// Optional build macro: DOOR_HOLD_EN adds the door_hold input, which
// restarts the door timer while the door is open.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   req_if         - request handshake (slave side)
//   door_hold      - keep door open (only with DOOR_HOLD_EN)
//   cur_floor_oh   - one-hot current floor (indicator lamps)
//   target_oh      - one-hot latched target, zero when idle
//   move_up/down   - motor commands
//   door_open      - door command
//   arrived        - one-cycle pulse on reaching the target
//   busy           - controller not idle
module floor_code_decoder_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter int FLOOR_W       = DEF_FLOOR_W,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    floor_code_decoder_ctrl_if.slave  req_if,
`ifdef DOOR_HOLD_EN
    input  logic                      door_hold,
`endif
    output logic [NUM_FLOORS-1:0]     cur_floor_oh,
    output logic [NUM_FLOORS-1:0]     target_oh,
    output logic                      move_up,
    output logic                      move_down,
    output logic                      door_open,
    output logic                      arrived,
    output logic                      busy
);

    localparam int TW = cnt_width(TRAVEL_CYCLES);
    localparam int DW = cnt_width(DOOR_CYCLES);
    localparam logic [TW-1:0] TRAV_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic [FLOOR_W-1:0] next_floor;
    logic [TW-1:0]      trav_cnt_q, trav_cnt_d;
    logic [DW-1:0]      door_cnt_q, door_cnt_d;
    logic               move_up_q, move_up_d;
    logic               move_down_q, move_down_d;
    logic               door_open_q, door_open_d;
    logic               arrived_q, arrived_d;
    logic               busy_q, busy_d;
    logic               req_ready_q, req_ready_d;
    logic               hold;

`ifdef DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        target_d   = target_q;
        trav_cnt_d = trav_cnt_q;
        door_cnt_d = door_cnt_q;
        next_floor = floor_q;
        case (state_q)
            IDLE: begin
                // Out-of-range codes complete the handshake but change nothing.
                if (req_if.req_valid && req_ready_q &&
                    (int'(req_if.req_floor) < NUM_FLOORS)) begin
                    target_d   = req_if.req_floor;
                    trav_cnt_d = '0;
                    door_cnt_d = '0;
                    if (req_if.req_floor == floor_q)
                        state_d = DOOR_OPEN;
                    else if (req_if.req_floor > floor_q)
                        state_d = MOVE_UP;
                    else
                        state_d = MOVE_DOWN;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (trav_cnt_q == TRAV_LAST) begin
                    trav_cnt_d = '0;
                    next_floor = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1)
                                                      : floor_q - FLOOR_W'(1);
                    floor_d    = next_floor;
                    // Leave the move state on the same edge the floor lands,
                    // so the motor command drops as the lamp changes.
                    if (next_floor == target_q) begin
                        state_d    = DOOR_OPEN;
                        door_cnt_d = '0;
                    end
                end else begin
                    trav_cnt_d = trav_cnt_q + TW'(1);
                end
            end
            DOOR_OPEN: begin
                if (hold) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = IDLE;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered copies of the next-state decode.
    always_comb begin
        move_up_d   = (state_d == MOVE_UP);
        move_down_d = (state_d == MOVE_DOWN);
        door_open_d = (state_d == DOOR_OPEN);
        busy_d      = (state_d != IDLE);
        req_ready_d = (state_d == IDLE);
        arrived_d   = (state_d == DOOR_OPEN) && (state_q != DOOR_OPEN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            target_q    <= '0;
            trav_cnt_q  <= '0;
            door_cnt_q  <= '0;
            move_up_q   <= 1'b0;
            move_down_q <= 1'b0;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            target_q    <= target_d;
            trav_cnt_q  <= trav_cnt_d;
            door_cnt_q  <= door_cnt_d;
            move_up_q   <= move_up_d;
            move_down_q <= move_down_d;
            door_open_q <= door_open_d;
            arrived_q   <= arrived_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    floor_onehot_decoder #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_cur_dec (
        .en     (1'b1),
        .code   (floor_q),
        .onehot (cur_floor_oh)
    );

    floor_onehot_decoder #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_tgt_dec (
        .en     (busy_q),
        .code   (target_q),
        .onehot (target_oh)
    );

    assign req_if.req_ready = req_ready_q;
    assign move_up          = move_up_q;
    assign move_down        = move_down_q;
    assign door_open        = door_open_q;
    assign arrived          = arrived_q;
    assign busy             = busy_q;

endmodule
